turn_sequencer: RTL and testbench

- Game-logic end of the renderer's turn interface: drives player1_pos_x, player2_pos_x, pos_valid and active_player, and consumes turn_done.
- Turn-based two-player board game. A roll request latches a dice value of 1..6 and advances the active player's tile, clamped at the flag tile.
- Issues a one-cycle position update, then waits for the renderer's turn_done before switching players or declaring a winner.
- Sits beside the UI renderer in the top level; fed by a debounced roll button.

---
 rtl/turn_sequencer_pkg.sv | 28 ++
 rtl/turn_sequencer_if.sv | 18 +
 rtl/turn_sequencer_dice_counter.sv | 23 ++
 rtl/turn_sequencer.sv | 174 +++++++++++++++++
 tb/tb_turn_sequencer.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/turn_sequencer_pkg.sv
// Shared definitions for the turn sequencer: FSM states, tile index type,
// dice and player constants, and the clamped tile-advance helper.
package turn_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE      = 2'd1,
    WAIT_DONE = 2'd2,
    GAME_OVER = 2'd3
  } state_e;

  typedef logic [4:0] tile_t;

  localparam logic [2:0] DICE_MIN = 3'd1;
  localparam logic [2:0] DICE_MAX = 3'd6;

  localparam logic P1 = 1'b0;
  localparam logic P2 = 1'b1;

  // Sum fits in 5 bits for any legal board, so clamping never sees a wrapped value.
  function automatic tile_t advance_tile(input tile_t cur, input logic [2:0] dice,
                                         input tile_t last);
    tile_t sum;
    sum = cur + tile_t'(dice);
    return (sum > last) ? last : sum;
  endfunction

endpackage

// File: rtl/turn_sequencer_if.sv
// Turn interface between game logic (master) and the UI renderer (slave).
interface turn_sequencer_if;
  logic [9:0] player1_pos_x;
  logic [9:0] player2_pos_x;
  logic       pos_valid;
  logic       active_player;
  logic       turn_done;

  modport master (
    output player1_pos_x, player2_pos_x, pos_valid, active_player,
    input  turn_done
  );

  modport slave (
    input  player1_pos_x, player2_pos_x, pos_valid, active_player,
    output turn_done
  );
endinterface

// File: rtl/turn_sequencer_dice_counter.sv
// Free-running dice counter cycling 1..6; restarts at 1 on synchronous reset.
module turn_sequencer_dice_counter
  import turn_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] value_o
);

  logic [2:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == DICE_MAX) ? DICE_MIN : cnt_q + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= DICE_MIN;
    else     cnt_q <= cnt_d;
  end

  assign value_o = cnt_q;

endmodule

// File: rtl/turn_sequencer.sv
// Two-player turn sequencer: latches a roll, advances the active player, then
// waits for the renderer. Optional turn_done watchdog under macro TURN_TIMEOUT_EN.
module turn_sequencer
  import turn_sequencer_pkg::*;
#(
  parameter int N_TILES        = 10,
  parameter int TILE_W         = 64,
  parameter int START_X        = 32,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             roll_btn,
  turn_sequencer_if.master turn_if,
  output logic [2:0]       dice_value,
  output logic             busy,
  output logic             winner_valid,
  output logic             winner_id,
  output logic             turn_timeout
);

  localparam tile_t      LAST_TILE = tile_t'(N_TILES - 1);
  localparam logic [9:0] X0        = 10'(START_X);

  function automatic logic [9:0] tile_to_x(input tile_t t);
    int x;
    x = START_X + int'(t) * TILE_W;
    return x[9:0];
  endfunction

  state_e     state_q, state_d;
  tile_t      tile1_q, tile1_d, tile2_q, tile2_d;
  logic [9:0] p1x_q, p1x_d, p2x_q, p2x_d;
  logic       pos_valid_q, pos_valid_d;
  logic       active_q, active_d;
  logic [2:0] dice_q, dice_d;
  logic       win_valid_q, win_valid_d;
  logic       win_id_q, win_id_d;

  logic [2:0] dice_roll;
  tile_t      cur_tile, new_tile;
  logic       done_evt;

  turn_sequencer_dice_counter u_dice (
    .clk     (clk),
    .rst     (rst),
    .value_o (dice_roll)
  );

  assign cur_tile = (active_q == P1) ? tile1_q : tile2_q;
  assign new_tile = advance_tile(cur_tile, dice_q, LAST_TILE);

`ifdef TURN_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TO_W-1:0] wd_q, wd_d;
  logic            timeout_q, timeout_d;
  logic            wd_reached;

  // Cycle index within WAIT_DONE: 0 on the first cycle, expiry on the last allowed one.
  assign wd_reached = (state_q == WAIT_DONE) && (wd_q == TO_W'(TIMEOUT_CYCLES - 1));
  assign done_evt   = turn_if.turn_done | wd_reached;

  always_comb begin
    wd_d      = wd_q;
    timeout_d = wd_reached & ~turn_if.turn_done;
    if (state_q == MOVE)           wd_d = '0;
    else if (state_q == WAIT_DONE) wd_d = wd_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign turn_timeout = timeout_q;
`else
  logic unused_cfg;
  assign unused_cfg   = (TIMEOUT_CYCLES != 0);
  assign done_evt     = turn_if.turn_done;
  assign turn_timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    tile1_d     = tile1_q;
    tile2_d     = tile2_q;
    p1x_d       = p1x_q;
    p2x_d       = p2x_q;
    pos_valid_d = 1'b0;
    active_d    = active_q;
    dice_d      = dice_q;
    win_valid_d = win_valid_q;
    win_id_d    = win_id_q;

    unique case (state_q)
      IDLE: begin
        if (roll_btn) begin
          dice_d  = dice_roll;
          state_d = MOVE;
        end
      end
      MOVE: begin
        if (active_q == P1) begin
          tile1_d = new_tile;
          p1x_d   = tile_to_x(new_tile);
        end else begin
          tile2_d = new_tile;
          p2x_d   = tile_to_x(new_tile);
        end
        pos_valid_d = 1'b1;
        state_d     = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (done_evt) begin
          if (cur_tile == LAST_TILE) begin
            win_valid_d = 1'b1;
            win_id_d    = active_q;
            state_d     = GAME_OVER;
          end else begin
            active_d = (active_q == P1) ? P2 : P1;
            state_d  = IDLE;
          end
        end
      end
      GAME_OVER: begin
        state_d = GAME_OVER;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tile1_q     <= '0;
      tile2_q     <= '0;
      p1x_q       <= X0;
      p2x_q       <= X0;
      pos_valid_q <= 1'b0;
      active_q    <= P1;
      dice_q      <= 3'd0;
      win_valid_q <= 1'b0;
      win_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      tile1_q     <= tile1_d;
      tile2_q     <= tile2_d;
      p1x_q       <= p1x_d;
      p2x_q       <= p2x_d;
      pos_valid_q <= pos_valid_d;
      active_q    <= active_d;
      dice_q      <= dice_d;
      win_valid_q <= win_valid_d;
      win_id_q    <= win_id_d;
    end
  end

  assign turn_if.player1_pos_x = p1x_q;
  assign turn_if.player2_pos_x = p2x_q;
  assign turn_if.pos_valid     = pos_valid_q;
  assign turn_if.active_player = active_q;

  assign dice_value   = dice_q;
  assign busy         = (state_q != IDLE);
  assign winner_valid = win_valid_q;
  assign winner_id    = win_id_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// Self-checking bench for turn_sequencer: table-driven game turns with a
// position scoreboard, plus hand-written reset, game-over and watchdog sequences.
module tb_turn_sequencer;
  import turn_sequencer_pkg::*;

  localparam int TO_CYC = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       roll_btn = 1'b0;
  logic [2:0] dice_value;
  logic       busy, winner_valid, winner_id, turn_timeout;

  turn_sequencer_if tif ();

  turn_sequencer #(
    .N_TILES        (10),
    .TILE_W         (64),
    .START_X        (32),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .roll_btn     (roll_btn),
    .turn_if      (tif),
    .dice_value   (dice_value),
    .busy         (busy),
    .winner_valid (winner_valid),
    .winner_id    (winner_id),
    .turn_timeout (turn_timeout)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int k = 0;

  // Cycle index since reset release; the dice counter shows (k mod 6)+1.
  always @(posedge clk) k <= rst ? 0 : k + 1;

  typedef struct {
    logic [9:0] p1x;
    logic [9:0] p2x;
    logic       act;
  } exp_t;

  typedef struct {
    int         dice;
    int         hold;
    bit         idle_done;
    logic [9:0] p1x;
    logic [9:0] p2x;
    logic       act;
    logic       act_after;
    logic       win;
  } vec_t;

  exp_t sb[$];
  logic pv_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (tif.pos_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected pos_valid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("player1_pos_x", 32'(tif.player1_pos_x), 32'(e.p1x));
        check("player2_pos_x", 32'(tif.player2_pos_x), 32'(e.p2x));
        check("active_at_pos_valid", 32'(tif.active_player), 32'(e.act));
      end
    end
    if (pv_prev && tif.pos_valid === 1'b1) check("pos_valid_width", 32'd2, 32'd1);
    pv_prev = (tif.pos_valid === 1'b1);
  end

  task automatic do_roll(input int dice, input int hold, input logic [9:0] p1x,
                         input logic [9:0] p2x, input logic act);
    exp_t e;
    int   guard;
    guard = 0;
    while ((((k % 6) + 1) != dice) && (guard < 20)) begin
      @(negedge clk);
      guard++;
    end
    e.p1x = p1x;
    e.p2x = p2x;
    e.act = act;
    sb.push_back(e);
    roll_btn = 1'b1;
    @(negedge clk);
    check("dice_value", 32'(dice_value), 32'(dice));
    if (hold <= 1) roll_btn = 1'b0;
    @(negedge clk);
    check("pos_valid_latency", 32'(tif.pos_valid), 32'd1);
    if (hold <= 2) roll_btn = 1'b0;
    @(negedge clk);
    roll_btn = 1'b0;
    check("pos_valid_drop", 32'(tif.pos_valid), 32'd0);
  endtask

  task automatic do_done();
    tif.turn_done = 1'b1;
    @(negedge clk);
    tif.turn_done = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_p1x"}, 32'(tif.player1_pos_x), 32'd32);
    check({tag, "_p2x"}, 32'(tif.player2_pos_x), 32'd32);
    check({tag, "_active"}, 32'(tif.active_player), 32'd0);
    check({tag, "_pos_valid"}, 32'(tif.pos_valid), 32'd0);
    check({tag, "_dice"}, 32'(dice_value), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_winner_valid"}, 32'(winner_valid), 32'd0);
    check({tag, "_winner_id"}, 32'(winner_id), 32'd0);
    check({tag, "_timeout"}, 32'(turn_timeout), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    vec_t vt[5];
    int   n;

    // P1 3 -> tile 3, P2 6 -> tile 6, P1 4 -> tile 7, P2 1 -> tile 7, P1 5 -> clamp 9
    vt[0] = '{dice: 3, hold: 1, idle_done: 1'b0, p1x: 10'd224, p2x: 10'd32,  act: 1'b0, act_after: 1'b1, win: 1'b0};
    vt[1] = '{dice: 6, hold: 1, idle_done: 1'b0, p1x: 10'd224, p2x: 10'd416, act: 1'b1, act_after: 1'b0, win: 1'b0};
    vt[2] = '{dice: 4, hold: 3, idle_done: 1'b1, p1x: 10'd480, p2x: 10'd416, act: 1'b0, act_after: 1'b1, win: 1'b0};
    vt[3] = '{dice: 1, hold: 1, idle_done: 1'b0, p1x: 10'd480, p2x: 10'd480, act: 1'b1, act_after: 1'b0, win: 1'b0};
    vt[4] = '{dice: 5, hold: 1, idle_done: 1'b0, p1x: 10'd608, p2x: 10'd480, act: 1'b0, act_after: 1'b0, win: 1'b1};

    tif.turn_done = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      if (vt[i].idle_done) begin
        do_done();
        @(negedge clk);
        check("idle_turn_done_active", 32'(tif.active_player), 32'(vt[i].act));
        check("idle_turn_done_busy", 32'(busy), 32'd0);
      end
      do_roll(vt[i].dice, vt[i].hold, vt[i].p1x, vt[i].p2x, vt[i].act);
      repeat (2) @(negedge clk);
      check("dice_held", 32'(dice_value), 32'(vt[i].dice));
      check("active_stable_wait", 32'(tif.active_player), 32'(vt[i].act));
      check("busy_wait", 32'(busy), 32'd1);
      do_done();
      check("active_after_done", 32'(tif.active_player), 32'(vt[i].act_after));
      check("winner_valid", 32'(winner_valid), 32'(vt[i].win));
      check("busy_after_done", 32'(busy), 32'(vt[i].win));
      if (vt[i].win) check("winner_id", 32'(winner_id), 32'd0);
    end

    // Game over: further inputs are ignored and outputs hold.
    roll_btn = 1'b1;
    tif.turn_done = 1'b1;
    @(negedge clk);
    roll_btn = 1'b0;
    tif.turn_done = 1'b0;
    repeat (4) @(negedge clk);
    check("go_winner_valid", 32'(winner_valid), 32'd1);
    check("go_winner_id", 32'(winner_id), 32'd0);
    check("go_busy", 32'(busy), 32'd1);
    check("go_p1x", 32'(tif.player1_pos_x), 32'd608);
    check("go_p2x", 32'(tif.player2_pos_x), 32'd480);
    check("go_dice", 32'(dice_value), 32'd5);
    check("go_active", 32'(tif.active_player), 32'd0);

    // Reset mid-turn, then a late turn_done.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    do_roll(2, 1, 10'd160, 10'd32, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    do_done();
    @(negedge clk);
    check_reset_state("midreset");

    // Watchdog: roll and never answer.
    do_roll(1, 1, 10'd96, 10'd32, 1'b0);
`ifdef TURN_TIMEOUT_EN
    n = 0;
    while ((turn_timeout !== 1'b1) && (n < 200)) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycle", 32'(n), 32'd99);
    check("timeout_active", 32'(tif.active_player), 32'd1);
    check("timeout_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("timeout_pulse_width", 32'(turn_timeout), 32'd0);
`else
    n = 0;
    repeat (300) begin
      @(negedge clk);
      if (turn_timeout !== 1'b0) n++;
    end
    check("no_timeout_pulse", 32'(n), 32'd0);
    check("no_timeout_busy", 32'(busy), 32'd1);
    check("no_timeout_active", 32'(tif.active_player), 32'd0);
    do_done();
    check("late_done_active", 32'(tif.active_player), 32'd1);
`endif
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
